// File: rtl/ser_pkg.sv
// rtl/ser_pkg.sv - shared constants and state enum; IDLE_COM selected by BYTE_SERIALIZER_IDLE_COM_EN
package ser_pkg;

  localparam int BYTE_W = 8;

`ifdef BYTE_SERIALIZER_IDLE_COM_EN
  localparam logic [BYTE_W-1:0] IDLE_COM = 8'hBC;
`else
  localparam logic [BYTE_W-1:0] IDLE_COM = 8'h00;
`endif

  typedef enum logic [1:0] {
    RESET     = 2'd0,
    SEND_IDLE = 2'd1,
    SEND_DATA = 2'd2
  } state_t;

endpackage

// File: rtl/byte_serializer.sv
// rtl/byte_serializer.sv - byte-to-bit serializer, MSB first, idle filler from BYTE_SERIALIZER_IDLE_COM_EN
import ser_pkg::*;

module byte_serializer (
  input  logic              clk_32f,
  input  logic              reset,
  input  logic              valid_in,
  input  logic [BYTE_W-1:0] data_in,
  output logic              data_out,
  output logic              active_out,
  output logic              byte_strobe
);

  logic [2:0]        cnt_q, cnt_d;
  logic [BYTE_W-1:0] shift_q, shift_d;
  state_t            state_q, state_d;
  logic              strobe_q, strobe_d;
  logic              load;

  // A new byte is taken only when the bit counter has wrapped to zero.
  always_comb begin
    cnt_d    = cnt_q + 3'd1;
    shift_d  = {shift_q[BYTE_W-2:0], 1'b0};
    state_d  = state_q;
    strobe_d = 1'b0;
    load     = (cnt_q == 3'd0);
    if (load) begin
      strobe_d = 1'b1;
      if (valid_in) begin
        shift_d = data_in;
        state_d = SEND_DATA;
      end else begin
        shift_d = IDLE_COM;
        state_d = SEND_IDLE;
      end
    end
  end

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      cnt_q    <= 3'd0;
      shift_q  <= '0;
      state_q  <= RESET;
      strobe_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      state_q  <= state_d;
      strobe_q <= strobe_d;
    end
  end

  assign data_out    = shift_q[BYTE_W-1];
  assign active_out  = (state_q == SEND_DATA);
  assign byte_strobe = strobe_q;

endmodule

// File: tb/tb_byte_serializer.sv
// tb/tb_byte_serializer.sv - table-driven bench for byte_serializer (honours BYTE_SERIALIZER_IDLE_COM_EN)
module tb_byte_serializer;

  logic       clk_32f;
  logic       reset;
  logic       valid_in;
  logic [7:0] data_in;
  logic       data_out;
  logic       active_out;
  logic       byte_strobe;

  int total = 0;
  int bad   = 0;

`ifdef BYTE_SERIALIZER_IDLE_COM_EN
  localparam logic [7:0] IDLE_EXP = 8'hBC;
`else
  localparam logic [7:0] IDLE_EXP = 8'h00;
`endif

  // mid: 0 = none, 1 = data_in -> 8'h3C at bit 3, 2 = valid_in drops at bit 3
  typedef struct {
    logic       v;
    logic [7:0] d;
    int         mid;
    logic [7:0] exp_bits;
    logic       exp_act;
  } vec_t;

  vec_t vecs[10];

  byte_serializer dut (
    .clk_32f    (clk_32f),
    .reset      (reset),
    .valid_in   (valid_in),
    .data_in    (data_in),
    .data_out   (data_out),
    .active_out (active_out),
    .byte_strobe(byte_strobe)
  );

  initial clk_32f = 1'b0;
  always #5 clk_32f = ~clk_32f;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int idx, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s[%0d]: got %0d want %0d", nm, idx, got, want);
    end
  endtask

  // Presents the record before the load edge, then checks all 8 output cycles.
  task automatic send_byte(input vec_t r, input int idx);
    logic [7:0] e;
    e = r.exp_bits;
    valid_in = r.v;
    data_in  = r.d;
    @(posedge clk_32f);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_32f);
      chk("data_out", idx * 8 + i, int'(data_out), int'(e[7-i]));
      chk("active_out", idx * 8 + i, int'(active_out), int'(r.exp_act));
      chk("byte_strobe", idx * 8 + i, int'(byte_strobe), (i == 0) ? 1 : 0);
      if (i == 3 && r.mid == 1) data_in = 8'h3C;
      if (i == 3 && r.mid == 2) valid_in = 1'b0;
    end
  endtask

  initial begin
    vec_t r81, rc5;
    logic [7:0] e81;

    vecs[0] = '{1'b0, 8'hFF, 0, IDLE_EXP, 1'b0};
    vecs[1] = '{1'b0, 8'h00, 0, IDLE_EXP, 1'b0};
    vecs[2] = '{1'b1, 8'hA5, 0, 8'hA5,    1'b1};
    vecs[3] = '{1'b1, 8'hFF, 0, 8'hFF,    1'b1};
    vecs[4] = '{1'b1, 8'h00, 0, 8'h00,    1'b1};
    vecs[5] = '{1'b1, 8'hC3, 1, 8'hC3,    1'b1};
    vecs[6] = '{1'b1, 8'h3C, 0, 8'h3C,    1'b1};
    vecs[7] = '{1'b1, 8'h5A, 2, 8'h5A,    1'b1};
    vecs[8] = '{1'b0, 8'h5A, 0, IDLE_EXP, 1'b0};
    vecs[9] = '{1'b1, 8'h01, 0, 8'h01,    1'b1};

    reset    = 1'b1;
    valid_in = 1'b0;
    data_in  = 8'h00;
    repeat (3) @(posedge clk_32f);
    @(negedge clk_32f);
    chk("rst_data_out", 0, int'(data_out), 0);
    chk("rst_active_out", 0, int'(active_out), 0);
    chk("rst_byte_strobe", 0, int'(byte_strobe), 0);
    reset = 1'b0;

    for (int k = 0; k < 10; k++) send_byte(vecs[k], k);

    // Reset pulse at counter=5 while 8'h81 is on the line.
    r81 = '{1'b1, 8'h81, 0, 8'h81, 1'b1};
    e81 = r81.exp_bits;
    valid_in = 1'b1;
    data_in  = 8'h81;
    @(posedge clk_32f);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_32f);
      chk("b81_data_out", i, int'(data_out), int'(e81[7-i]));
      chk("b81_active_out", i, int'(active_out), 1);
    end
    reset = 1'b1;
    @(negedge clk_32f);
    chk("midrst_data_out", 0, int'(data_out), 0);
    chk("midrst_active_out", 0, int'(active_out), 0);
    chk("midrst_byte_strobe", 0, int'(byte_strobe), 0);
    reset = 1'b0;
    rc5 = '{1'b1, 8'hC5, 0, 8'hC5, 1'b1};
    send_byte(rc5, 20);
    send_byte(vecs[1], 21);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/byte_serializer.md
BYTE_SERIALIZER -- requirements
Module: byte_serializer

Interface
REQ-001 Port clk_32f, input, 1 bit: single clock, 8x the byte rate; all state changes on its rising edge.
REQ-002 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 Port valid_in, input, 1 bit: data_in carries a valid byte.
REQ-004 Port data_in, input, 8 bits: parallel byte from the 32-to-8 stage, MSB is bit 7.
REQ-005 Port data_out, output, 1 bit: serial line.
REQ-006 Port active_out, output, 1 bit: high while the bit on data_out belongs to a data byte, not an idle byte.
REQ-007 Port byte_strobe, output, 1 bit: one-cycle pulse in the cycle where the shifter loads a new byte.

Function
REQ-008 The block SHALL keep a 3-bit bit counter that increments every cycle out of reset and wraps from 7 to 0.
REQ-009 The block SHALL sample valid_in and data_in only on edges where the counter equals 0; values at other counts SHALL be ignored.
REQ-010 On a load edge with valid_in=1, the 8-bit shifter SHALL load data_in and the state SHALL become SEND_DATA.
REQ-011 On a load edge with valid_in=0, the shifter SHALL load IDLE_COM and the state SHALL become SEND_IDLE.
REQ-012 On non-load edges, the shifter SHALL shift left by one and fill with 0.
REQ-013 data_out SHALL equal shifter bit 7, so the byte goes out MSB first.
REQ-014 Bit 7 of a byte loaded at edge k SHALL be on data_out during cycle k+1, and bit 0 during cycle k+8 (latency one cycle, no gaps).
REQ-015 active_out SHALL be 1 exactly when the state is SEND_DATA.
REQ-016 byte_strobe SHALL be 1 in the cycle after each load edge.
REQ-017 The state machine SHALL have three states: RESET, SEND_IDLE and SEND_DATA.
REQ-018 RESET SHALL move to SEND_IDLE or SEND_DATA only on the first load edge.
REQ-019 SEND_IDLE and SEND_DATA SHALL change state only on load edges.
REQ-020 If valid_in drops in the middle of a byte, the current byte SHALL complete unchanged.
REQ-021 Back-to-back valid bytes SHALL be serialized with no idle bits between them.

Reset
REQ-022 While reset=1 at an edge, the block SHALL set counter=0, shifter=0, state=RESET, data_out=0, active_out=0 and byte_strobe=0.
REQ-023 The first edge with reset=0 SHALL be a load edge (counter=0).
REQ-024 Reset asserted in the middle of a byte SHALL discard that byte, with outputs 0 from the next cycle.

Configuration
REQ-025 With BYTE_SERIALIZER_IDLE_COM_EN defined, IDLE_COM SHALL be 8'hBC.
REQ-026 Without BYTE_SERIALIZER_IDLE_COM_EN, IDLE_COM SHALL be 8'h00, so the line is held low when idle; active_out behaviour SHALL be unchanged.

Structure
REQ-027 Shared package ser_pkg SHALL hold the IDLE_COM constant (macro-selected), the state enum {RESET, SEND_IDLE, SEND_DATA} and BYTE_W=8.
REQ-028 The design SHALL be a single module with no sub-module; the counter and shifter are inline.

Verification
REQ-029 Reset held 3 cycles, then released with valid_in=0 (macro on) -> from cycle 1: data_out 1,0,1,1,1,1,0,0 repeating; active_out=0; byte_strobe every 8th cycle.
REQ-030 valid_in=1, data_in=8'hA5 at the load edge -> data_out 1,0,1,0,0,1,0,1 and active_out=1 for those 8 cycles.
REQ-031 Consecutive bytes 8'hFF then 8'h00 -> 8 ones then 8 zeros with no gap; active_out=1 throughout.
REQ-032 data_in changed to 8'h3C at counter=3 while 8'hC3 is being sent -> output stays 1,1,0,0,0,0,1,1; 8'h3C is taken only if still present at the next load edge.
REQ-033 reset pulsed for 1 cycle at counter=5 during 8'h81 -> data_out=0 and active_out=0 next cycle; next load on the first edge after release.
REQ-034 Macro off, valid_in=0 -> data_out constant 0 and active_out=0; byte_strobe cadence unchanged.
